// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART arbitration/fan-out blocks.
`default_nettype none

package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  // Index following idx in a ring of n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arb_if.sv
// Requester byte streams plus the uart_tx handshake, as seen by uart_tx_arb.
`default_nettype none

interface uart_tx_arb_if #(
  parameter int NREQ = 4
) ();
  import uart_pkg::*;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*UART_DW-1:0] req_data;
  logic [NREQ-1:0]         req_last;
  logic [NREQ-1:0]         req_ready;
  logic                    tx_valid;
  logic [UART_DW-1:0]      tx_data;
  logic                    tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );

endinterface

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
`default_nettype none

module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PTRW-1:0] o_idx,
  output logic            o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = PTRW'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NREQ requesters.
`default_nettype none

module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GAPW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_txen,
  input  logic [GAPW-1:0]  cfg_gap,
  uart_tx_arb_if.slave     bus,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t         r_state,    w_state_n;
  logic [NREQ-1:0]    r_grant,    w_grant_n;
  logic [PTRW-1:0]    r_gidx,     w_gidx_n;
  logic [PTRW-1:0]    r_rr_ptr,   w_rr_ptr_n;
  logic               r_hold_vld, w_hold_vld_n;
  logic               r_hold_last, w_hold_last_n;
  logic [UART_DW-1:0] r_hold_data, w_hold_data_n;
  logic               r_cool,     w_cool_n;
  logic               r_tx_valid, w_tx_valid_n;
  logic [GAPW-1:0]    r_gap_cnt,  w_gap_cnt_n;

  logic [NREQ-1:0]    w_pick_gnt;
  logic [PTRW-1:0]    w_pick_idx;
  logic               w_pick_any;
  logic [NREQ-1:0]    w_req_ready;
  logic               w_acc;
  logic               w_xfer;
  logic [UART_DW-1:0] w_sel_data;
  logic               w_sel_last;

  uart_rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Only the owner can see ready, and only while the hold slot is free.
  always_comb begin
    w_req_ready = '0;
    if (r_state == ARB_SEND && !r_hold_vld)
      w_req_ready = bus.req_valid & r_grant;
    w_acc      = |w_req_ready;
    w_xfer     = r_tx_valid & bus.tx_ready;
    w_sel_data = bus.req_data[int'(r_gidx)*UART_DW +: UART_DW];
    w_sel_last = bus.req_last[r_gidx];
  end

  always_comb begin
    w_state_n     = r_state;
    w_grant_n     = r_grant;
    w_gidx_n      = r_gidx;
    w_rr_ptr_n    = r_rr_ptr;
    w_hold_vld_n  = r_hold_vld;
    w_hold_last_n = r_hold_last;
    w_hold_data_n = r_hold_data;
    w_gap_cnt_n   = r_gap_cnt;
    // uart_tx leaves tx_ready high one cycle past acceptance; cool masks it.
    w_cool_n      = w_xfer;

    if (w_xfer)
      w_hold_vld_n = 1'b0;
    if (w_acc) begin
      w_hold_vld_n  = 1'b1;
      w_hold_data_n = w_sel_data;
      w_hold_last_n = w_sel_last;
    end

    case (r_state)
      ARB_IDLE: begin
        if (cfg_txen && w_pick_any) begin
          w_state_n  = ARB_SEND;
          w_grant_n  = w_pick_gnt;
          w_gidx_n   = w_pick_idx;
          w_rr_ptr_n = PTRW'(rr_next(int'(w_pick_idx), NREQ));
        end
      end
      ARB_SEND: begin
        if (w_xfer && r_hold_last) begin
          w_grant_n = '0;
          if (cfg_gap == '0) begin
            w_state_n = ARB_IDLE;
          end else begin
            w_gap_cnt_n = cfg_gap;
            w_state_n   = ARB_GAP;
          end
        end
      end
      ARB_GAP: begin
        w_gap_cnt_n = r_gap_cnt - GAPW'(1);
        if (r_gap_cnt <= GAPW'(1))
          w_state_n = ARB_IDLE;
      end
      default: w_state_n = ARB_IDLE;
    endcase

    w_tx_valid_n = w_hold_vld_n & ~w_cool_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_rr_ptr    <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_last <= 1'b0;
      r_hold_data <= '0;
      r_cool      <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_grant     <= w_grant_n;
      r_gidx      <= w_gidx_n;
      r_rr_ptr    <= w_rr_ptr_n;
      r_hold_vld  <= w_hold_vld_n;
      r_hold_last <= w_hold_last_n;
      r_hold_data <= w_hold_data_n;
      r_cool      <= w_cool_n;
      r_tx_valid  <= w_tx_valid_n;
      r_gap_cnt   <= w_gap_cnt_n;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_hold_data;
  assign grant         = r_grant;
  assign busy          = (r_state != ARB_IDLE) | r_hold_vld;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a small behavioural uart_tx handshake model.
`default_nettype none

module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int GAPW = 16;
  localparam int BUSY = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_txen = 1'b1;
  logic [GAPW-1:0] cfg_gap = '0;
  logic [NREQ-1:0] grant;
  logic            busy;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .GAPW(GAPW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_txen (cfg_txen),
    .cfg_gap  (cfg_gap),
    .bus      (bus.slave),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester queues: bit 8 is the last flag.
  logic [8:0]      rq [NREQ][$];
  logic [NREQ-1:0] rq_fire = '0;
  logic [7:0]      tx_log [$];
  logic [NREQ-1:0] g_log [$];
  logic [7:0]      e_d [$];
  logic [NREQ-1:0] e_g [$];
  logic            tx_fire = 1'b0;
  logic [7:0]      tx_fire_data = '0;
  logic [NREQ-1:0] tx_fire_grant = '0;
  logic            m_block = 1'b0;
  logic            m_force = 1'b0;
  int              m_cnt = 0;
  int              ready_bad = 0;
  int              gap_obs = 0;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b1;
  end

  // Requester drivers and uart_tx handshake model, all acting at the falling edge.
  always @(negedge clk) begin
    logic after;
    for (int i = 0; i < NREQ; i++)
      if (rq_fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    after = tx_fire;
    if (tx_fire) begin
      tx_log.push_back(tx_fire_data);
      g_log.push_back(tx_fire_grant);
    end
    if (m_block)       bus.tx_ready = 1'b0;
    else if (m_force)  bus.tx_ready = 1'b1;
    else if (tx_fire) begin
      bus.tx_ready = 1'b1;
      m_cnt        = BUSY;
    end else if (m_cnt > 0) begin
      bus.tx_ready = 1'b0;
      m_cnt--;
    end else       bus.tx_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = (rq[i].size() > 0);
      bus.req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
      bus.req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
    end
    #1;
    tx_fire       = bus.tx_valid & bus.tx_ready & rst;
    tx_fire_data  = bus.tx_data;
    tx_fire_grant = grant;
    rq_fire       = bus.req_valid & bus.req_ready & {NREQ{rst}};
    if (rst) begin
      if (after) check("txv_after_xfer", {31'd0, bus.tx_valid}, 32'd0);
      if ((bus.req_ready & ~grant) != '0) ready_bad++;
      if (busy && grant == '0 && !bus.tx_valid) gap_obs++;
    end
  end

  task automatic clear_bench();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    tx_log.delete();
    g_log.delete();
    e_d.delete();
    e_g.delete();
    rq_fire   = '0;
    tx_fire   = 1'b0;
    m_cnt     = 0;
    ready_bad = 0;
    gap_obs   = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    clear_bench();
    rst = 1'b1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_byte(input logic [7:0] d, input int r);
    e_d.push_back(d);
    e_g.push_back(NREQ'(1 << r));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk); #2;
      ok = (tx_log.size() >= e_d.size()) && !busy;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) ok = 1'b0;
    end
    check({tag, "_drain"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, tx_log.size(), e_d.size());
    for (int i = 0; i < e_d.size() && i < tx_log.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), {24'd0, tx_log[i]}, {24'd0, e_d[i]});
      check($sformatf("%s_grant%0d", tag, i), {28'd0, g_log[i]}, {28'd0, e_g[i]});
    end
    check({tag, "_ready_leak"}, ready_bad, 0);
  endtask

  initial begin
    #12;
    check("rst_grant",   {28'd0, grant}, 32'd0);
    check("rst_txvalid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_txdata",  {24'd0, bus.tx_data}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_ready",   {28'd0, bus.req_ready}, 32'd0);

    // Two-byte packet from req0, no gap.
    do_reset();
    cfg_gap = '0;
    push(0, 8'h55, 1'b0); push(0, 8'hA3, 1'b1);
    expect_byte(8'h55, 0); expect_byte(8'hA3, 0);
    wait_drain("t1", 200);
    check_log("t1");
    check("t1_grant_end", {28'd0, grant}, 32'd0);
    check("t1_gap0", gap_obs, 0);

    // All four valid, two one-byte packets each: strict round-robin.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      push(i, 8'h10 + 8'(i), 1'b1);
      push(i, 8'h20 + 8'(i), 1'b1);
    end
    for (int i = 0; i < NREQ; i++) expect_byte(8'h10 + 8'(i), i);
    for (int i = 0; i < NREQ; i++) expect_byte(8'h20 + 8'(i), i);
    wait_drain("t2", 600);
    check_log("t2");

    // req1 holds the transmitter for its whole packet while req2 waits.
    do_reset();
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
    push(2, 8'h41, 1'b1);
    expect_byte(8'h31, 1); expect_byte(8'h32, 1); expect_byte(8'h33, 1);
    expect_byte(8'h41, 2);
    wait_drain("t3", 400);
    check_log("t3");

    // tx_ready stuck high: cool must still give one transfer per byte.
    do_reset();
    m_force = 1'b1;
    for (int i = 1; i <= 4; i++) push(0, 8'(i), (i == 4));
    for (int i = 1; i <= 4; i++) expect_byte(8'(i), 0);
    wait_drain("t4", 200);
    check_log("t4");
    m_force = 1'b0;

    // 20-cycle gap after each of two packets.
    do_reset();
    cfg_gap = 16'd20;
    push(0, 8'h51, 1'b1); push(1, 8'h52, 1'b1);
    expect_byte(8'h51, 0); expect_byte(8'h52, 1);
    wait_drain("t5", 400);
    check_log("t5");
    check("t5_gap_cycles", gap_obs, 40);
    cfg_gap = '0;

    // Async reset with a byte held, then cfg_txen gating.
    do_reset();
    m_block = 1'b1;
    push(0, 8'h66, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    check("t6_pre_grant",   {28'd0, grant}, 32'd1);
    check("t6_pre_txvalid", {31'd0, bus.tx_valid}, 32'd1);
    check("t6_pre_txdata",  {24'd0, bus.tx_data}, 32'h66);
    rst = 1'b0;
    #1;
    check("t6_rst_grant",   {28'd0, grant}, 32'd0);
    check("t6_rst_txvalid", {31'd0, bus.tx_valid}, 32'd0);
    check("t6_rst_txdata",  {24'd0, bus.tx_data}, 32'd0);
    check("t6_rst_busy",    {31'd0, busy}, 32'd0);
    check("t6_rst_ready",   {28'd0, bus.req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    clear_bench();
    m_block  = 1'b0;
    cfg_txen = 1'b0;
    rst      = 1'b1;
    push(3, 8'h73, 1'b1); push(0, 8'h70, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    check("t6_txen0_grant", {28'd0, grant}, 32'd0);
    check("t6_txen0_busy",  {31'd0, busy}, 32'd0);
    check("t6_txen0_log",   tx_log.size(), 0);
    cfg_txen = 1'b1;
    expect_byte(8'h70, 0); expect_byte(8'h73, 3);
    wait_drain("t6", 300);
    check_log("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
